// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg
//   Shared definitions for the Booth multiplier arbiter slice:
//   - state_t : control FSM encoding (IDLE / BUSY / DONE)
//   - ADD/SUB : Booth pair codes for {x[i], x[i-1]}
//   - idw_of  : requester-index width helper (at least one bit)
//   The top module's file header names the optional build macro.
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_seq_core.sv
// booth_seq_core
//   Iterative radix-2 Booth datapath. It retires one multiplier bit per step.
//   Ports:
//     clk, rst_n : clock and synchronous active-low reset
//     load       : capture x (multiplier) and y (multiplicand), clear accumulator
//     step       : perform one Booth add/sub followed by an arithmetic shift
//     x, y       : W-bit signed operands
//     z          : 2W-bit signed product, valid after W steps
//   The multiplicand is sign-extended to W+1 bits. The high accumulator half is
//   also W+1 bits. This keeps -2^(W-1) exact without a correction step.
module booth_seq_core
  import booth_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z
);

  // The shift register is {a_reg, q_reg}, which is 2W+1 bits. q1_reg holds x[i-1].
  logic [W:0]   a_reg;
  logic [W:0]   a_next;
  logic [W:0]   m_reg;
  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;
  logic         q1_reg;
  logic         q1_next;
  logic [W:0]   a_sum;

  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], q1_reg})
      ADD:     a_sum = a_reg + m_reg;
      SUB:     a_sum = a_reg - m_reg;
      default: a_sum = a_reg;
    endcase
    // Shift the whole {A, Q, q1} chain arithmetically right by one.
    a_next  = {a_sum[W], a_sum[W:1]};
    q_next  = {a_sum[0], q_reg[W-1:1]};
    q1_next = q_reg[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      m_reg  <= '0;
      q_reg  <= '0;
      q1_reg <= 1'b0;
    end else if (load) begin
      a_reg  <= '0;
      m_reg  <= {y[W-1], y};
      q_reg  <= x;
      q1_reg <= 1'b0;
    end else if (step) begin
      a_reg  <= a_next;
      q_reg  <= q_next;
      q1_reg <= q1_next;
    end
  end

  // After W steps the top accumulator bit only repeats the sign bit.
  assign z = {a_reg[W-1:0], q_reg};

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Shares one iterative Booth multiplier among N requesters.
//   Ports:
//     clk, rst_n  : clock and synchronous active-low reset
//     req_valid   : per-requester request (N)
//     req_ready   : one-hot grant while IDLE, otherwise zero (N)
//     req_x/req_y : packed operands, requester i at [i*W +: W]
//     rsp_valid   : registered product valid
//     rsp_ready   : consumer accept
//     rsp_id      : index of the requester that owns rsp_z
//     rsp_z       : signed 2W-bit product
//   Build option: BOOTH_ARB_RR_EN selects round-robin arbitration that starts
//   its search at rr_ptr. When the macro is not defined, arbitration is fixed
//   priority and the lowest index wins.
//   Timing: an accept in cycle t gives rsp_valid high in cycle t+W+1.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 4,
  localparam int IDW = idw_of(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_x,
  input  logic [N*W-1:0] req_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [2*W-1:0] rsp_z
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_reg;
  state_t         state_next;
  logic [CW-1:0]  cnt_reg;
  logic [CW-1:0]  cnt_next;
  logic [IDW-1:0] rsp_id_reg;
  logic           rsp_valid_reg;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           found;
  logic           load;
  logic           step;
  logic [W-1:0]   sel_x;
  logic [W-1:0]   sel_y;

  // Arbiter
`ifdef BOOTH_ARB_RR_EN
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW:0]   pos;
  logic [IDW-1:0] pos_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    pos_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Walk upward from rr_ptr and wrap modulo N.
      pos = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(N)) pos = pos - (IDW+1)'(N);
      pos_idx = pos[IDW-1:0];
      if (!found && req_valid[pos_idx]) begin
        grant[pos_idx] = 1'b1;
        grant_idx      = pos_idx;
        found          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (load) begin
      rr_ptr_reg <= (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
        found     = 1'b1;
      end
    end
  end
`endif

  // Requesters are masked while reset is asserted, so a grant cannot be taken during reset.
  assign req_ready = (state_reg == IDLE && rst_n) ? grant : '0;

  // Control FSM
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step     = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(W-1)) state_next = DONE;
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rsp_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= (state_next == DONE);
      if (load) rsp_id_reg <= grant_idx;
    end
  end

  assign sel_x = req_x[grant_idx*W +: W];
  assign sel_y = req_y[grant_idx*W +: W];

  booth_seq_core #(.W(W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .x     (sel_x),
    .y     (sel_y),
    .z     (rsp_z)
  );

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_z;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int rr_ptr_m = 0;   // reference round-robin pointer

  booth_mul_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule applied to a request vector.
  function automatic int pick(input logic [N-1:0] v);
`ifdef BOOTH_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      if (v[(rr_ptr_m + k) % N]) return (rr_ptr_m + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (2*W)'(sa * sb);
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    rr_ptr_m = 0;
    #1;
  endtask

  // Runs a single request from requester `who` through to the response handshake.
  task automatic do_op(input int who, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int stall, input bit poke, output logic [2*W-1:0] z_out);
    int exp_g;
    int waited;
    logic [N-1:0]   exp_rdy;
    logic [2*W-1:0] exp_z;
    exp_z = ref_mul(x, y);
    z_out = 'x;
    req_x[who*W +: W] = x;
    req_y[who*W +: W] = y;
    req_valid = '0;
    req_valid[who] = 1'b1;
    #1;
    waited = 0;
    while (req_ready === '0 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      fails++;
      $display("FAIL accept_timeout: req_ready=%b required grant to %0d", req_ready, who);
      req_valid = '0;
      return;
    end
    passes++;
    exp_g = pick(req_valid);
    exp_rdy = '0;
    exp_rdy[exp_g] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      fails++;
      $display("FAIL grant: req_ready=%b required %b", req_ready, exp_rdy);
    end else passes++;
    tick();  // handshake edge
    rr_ptr_m = (exp_g + 1) % N;
    req_valid = '0;
    if (poke) req_valid[(who + 1) % N] = 1'b1;
    #1;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
        fails++;
        $display("FAIL busy_cycle%0d: rsp_valid=%b req_ready=%b required 0/0", k, rsp_valid, req_ready);
      end else passes++;
      rsp_ready = 1'($urandom_range(0, 1));  // ignored while not valid
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== exp_z || rsp_id !== IDW'(who)) begin
      fails++;
      $display("FAIL result: valid=%b z=%h id=%0d required valid=1 z=%h id=%0d",
               rsp_valid, rsp_z, rsp_id, exp_z, who);
    end else passes++;
    z_out = rsp_z;
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_z !== exp_z || rsp_id !== IDW'(who) || req_ready !== '0) begin
        fails++;
        $display("FAIL hold%0d: valid=%b z=%h id=%0d rdy=%b required 1 %h %0d 0",
                 s, rsp_valid, rsp_z, rsp_id, req_ready, exp_z, who);
      end else passes++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsp_release: rsp_valid=%b required 0", rsp_valid);
    end else passes++;
    $display("op id=%0d x=%h y=%h z=%h expected=%h stall=%0d", who, x, y, z_out, exp_z, stall);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_x = '0;
    req_y = '0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_z !== '0 || rsp_id !== '0 || req_ready !== '0) begin
      fails++;
      $display("FAIL reset: valid=%b z=%h id=%0d rdy=%b required all zero",
               rsp_valid, rsp_z, rsp_id, req_ready);
    end else passes++;
    req_valid = '0;
    rst_n = 1'b1;
    rr_ptr_m = 0;
    #1;
    $display("reset done");
  endtask

  task automatic test_basic();
    logic [2*W-1:0] z;
    do_op(0, 4'h3, 4'hE, 0, 1'b0, z);
    checks++;
    if (z !== 8'hFA) begin fails++; $display("FAIL basic_3x-2: z=%h required fa", z); end
    else passes++;
  endtask

  task automatic test_corners();
    logic [2*W-1:0] z;
    do_op(1, 4'h8, 4'h8, 0, 1'b0, z);
    checks++;
    if (z !== 8'h40) begin fails++; $display("FAIL corner_-8x-8: z=%h required 40", z); end
    else passes++;
    do_op(2, 4'h8, 4'h7, 0, 1'b0, z);
    checks++;
    if (z !== 8'hC8) begin fails++; $display("FAIL corner_-8x7: z=%h required c8", z); end
    else passes++;
    do_op(3, 4'h7, 4'h7, 0, 1'b0, z);
    checks++;
    if (z !== 8'h31) begin fails++; $display("FAIL corner_7x7: z=%h required 31", z); end
    else passes++;
  endtask

  task automatic test_contention();
    int exp_g;
    int seq_exp [4];
    logic [N-1:0] exp_rdy;
    logic [2*W-1:0] exp_z;
`ifdef BOOTH_ARB_RR_EN
    seq_exp = '{0, 2, 0, 2};
`else
    seq_exp = '{0, 0, 0, 0};
`endif
    apply_reset();
    req_x[0*W +: W] = 4'h5; req_y[0*W +: W] = 4'hD;
    req_x[2*W +: W] = 4'hA; req_y[2*W +: W] = 4'h2;
    req_valid = 4'b0101;
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_g = pick(req_valid);
      exp_rdy = '0;
      exp_rdy[exp_g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy || exp_g != seq_exp[r]) begin
        fails++;
        $display("FAIL contention_grant%0d: req_ready=%b required %b (seq %0d)",
                 r, req_ready, exp_rdy, seq_exp[r]);
      end else passes++;
      tick();
      rr_ptr_m = (exp_g + 1) % N;
      for (int k = 0; k < W; k++) tick();
      exp_z = ref_mul(req_x[exp_g*W +: W], req_y[exp_g*W +: W]);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_g) || rsp_z !== exp_z) begin
        fails++;
        $display("FAIL contention_rsp%0d: valid=%b id=%0d z=%h required 1 %0d %h",
                 r, rsp_valid, rsp_id, rsp_z, exp_g, exp_z);
      end else passes++;
      $display("contention round=%0d grant=%0d z=%h", r, rsp_id, rsp_z);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
    end
    // Once requester 0 drops out, requester 2 must be granted.
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL contention_drop: req_ready=%b required 0100", req_ready);
    end else passes++;
    req_valid = '0;
    #1;
  endtask

  task automatic test_stall();
    logic [2*W-1:0] z;
    do_op(1, 4'hB, 4'h6, 5, 1'b1, z);
  endtask

  task automatic test_abort();
    logic [2*W-1:0] z;
    req_x[1*W +: W] = 4'h6;
    req_y[1*W +: W] = 4'h5;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL abort_accept: req_ready=%b required 0010", req_ready);
    end else passes++;
    tick();            // accepted; BUSY step 0
    req_valid = '0;
    tick();            // step 1
    tick();            // step 2
    rst_n = 1'b0;
    req_valid = 4'b1000;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      fails++;
      $display("FAIL abort_reset: valid=%b rdy=%b required 0/0", rsp_valid, req_ready);
    end else passes++;
    req_valid = '0;
    rst_n = 1'b1;
    rr_ptr_m = 0;
    #1;
    for (int k = 0; k < W + 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_ghost%0d: rsp_valid=%b required 0", k, rsp_valid);
      end else passes++;
      tick();
    end
    $display("abort done");
    do_op(3, 4'h9, 4'h3, 1, 1'b0, z);
  endtask

  task automatic test_exhaustive();
    logic [2*W-1:0] z;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        xv = W'(a);
        yv = W'(b);
        do_op(int'($urandom_range(0, N-1)), xv, yv, int'($urandom_range(0, 2)), 1'b0, z);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_x = '0;
    req_y = '0;
    test_reset();
    test_basic();
    test_corners();
    test_contention();
    test_stall();
    test_abort();
    test_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard time limit so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
